// File: rtl/float2int_pkg.sv
// Shared widths, FSM state type and the reference decode for the 7-bit compact float.
package float2int_pkg;
   localparam int E_W   = 3;
   localparam int M_W   = 4;
   localparam int INT_W = 11;

   typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

   // value = m for e==0, else (16+m) << (e-1); midpoint fills bit (e-2) when e>=2
   function automatic logic [INT_W-1:0] ref_decode(input logic [E_W-1:0] e,
                                                   input logic [M_W-1:0] m,
                                                   input logic           midpoint);
      logic [INT_W-1:0] v;
      v = {{(INT_W-M_W){1'b0}}, m};
      if (e != '0) begin
         v = v | (INT_W'(1) << M_W);
         v = v << (e - 3'd1);
         if (midpoint && e >= 3'd2) v = v | (INT_W'(1) << (e - 3'd2));
      end
      return v;
   endfunction
endpackage

// File: rtl/float2int_dec.sv
// Iterative compact-float to integer decoder: one left shift per cycle,
// valid/ready on both sides, back-to-back accept from OUT.
module float2int_dec
   import float2int_pkg::*;
#(
   parameter bit MIDPOINT = 1'b0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [INT_W-1:0] out_data,
   output logic             busy,
   output logic [CNT_W-1:0] conv_count
);

   state_t           state;
   logic [INT_W-1:0] acc;
   logic [E_W-1:0]   cnt;
   logic [E_W-1:0]   e_r;
   logic [M_W-1:0]   m_r;
   logic [E_W-1:0]   e_in;
   logic [M_W-1:0]   m_in;
   logic             accept;
   logic [INT_W-1:0] mid_bit;

   assign e_in      = in_data[6:4];
   assign m_in      = in_data[3:0];
   assign in_ready  = (state == IDLE) || (state == OUT && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE);
   assign out_data  = acc;

   // The last shift leaves bits [e-2:0] zero, so the midpoint bit is OR'd in on that step
   always_comb begin
      mid_bit = '0;
      if (MIDPOINT && cnt == 3'd1) mid_bit = INT_W'(1) << (e_r - 3'd2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         acc        <= '0;
         cnt        <= '0;
         e_r        <= '0;
         m_r        <= '0;
         conv_count <= '0;
      end else begin
         if (out_valid && out_ready) conv_count <= conv_count + CNT_W'(1);
         case (state)
            IDLE, OUT: begin
               if (accept) begin
                  acc   <= {{(INT_W-M_W-1){1'b0}}, (e_in != '0), m_in};
                  cnt   <= (e_in == '0) ? '0 : e_in - 3'd1;
                  e_r   <= e_in;
                  m_r   <= m_in;
                  state <= (e_in <= 3'd1) ? OUT : SHIFT;
               end else if (state == OUT && out_ready) begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               acc <= (acc << 1) | mid_bit;
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) state <= OUT;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always @(posedge clk) begin
      if (!rst && state == OUT) assert (acc == ref_decode(e_r, m_r, MIDPOINT));
   end

endmodule

// File: tb/tb_float2int_dec.sv
// Scoreboard bench for float2int_dec; two instances (MIDPOINT 0/1) share all inputs.
module tb_float2int_dec;
   import float2int_pkg::*;

   typedef struct {
      logic [INT_W-1:0] v0;
      logic [INT_W-1:0] v1;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid, out_ready;
   logic [6:0]       in_data;
   logic             in_ready, out_valid, busy;
   logic [INT_W-1:0] out_data;
   logic [15:0]      conv_count;
   logic             in_ready_mp, out_valid_mp, busy_mp;
   logic [INT_W-1:0] out_data_mp;
   logic [15:0]      conv_count_mp;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   hs       = 0;
   logic last_acc;
   exp_t sbq[$];

   always #5 clk = ~clk;

   float2int_dec #(.MIDPOINT(1'b0), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
      .conv_count(conv_count));

   float2int_dec #(.MIDPOINT(1'b1), .CNT_W(16)) dut_mp (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_mp), .in_data(in_data),
      .out_valid(out_valid_mp), .out_ready(out_ready), .out_data(out_data_mp), .busy(busy_mp),
      .conv_count(conv_count_mp));

   // One clock: sample at negedge (pop results, push accepted words), return just after posedge
   task automatic tick();
      exp_t x;
      @(negedge clk);
      last_acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         hs++;
         n_checks++;
         if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got %0d, no result expected", out_data);
         end else begin
            x = sbq.pop_front();
            if (out_data !== x.v0 || out_data_mp !== x.v1 || out_valid_mp !== 1'b1) begin
               n_fail++;
               $display("FAIL sb_data: got %0d/%0d, expected %0d/%0d",
                        out_data, out_data_mp, x.v0, x.v1);
            end
         end
      end
      if (last_acc) begin
         x.v0 = ref_decode(in_data[6:4], in_data[3:0], 1'b0);
         x.v1 = ref_decode(in_data[6:4], in_data[3:0], 1'b1);
         sbq.push_back(x);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin tick(); n++; end
      n_checks++;
      if (busy) begin n_fail++; $display("FAIL idle_timeout: busy=%0b expected 0", busy); end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      #3;
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== '0 || conv_count !== '0) begin
         n_fail++;
         $display("FAIL reset: rdy=%0b vld=%0b busy=%0b data=%0d cnt=%0d expected 1 0 0 0 0",
                  in_ready, out_valid, busy, out_data, conv_count);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 7'h00;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 11'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first: vld=%0b data=%0d rdy=%0b expected 1 0 1", out_valid, out_data, in_ready);
      end
      in_data = 7'h0F;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 11'd15 || in_ready !== 1'b1 || !last_acc) begin
         n_fail++;
         $display("FAIL b2b_second: vld=%0b data=%0d rdy=%0b acc=%0b expected 1 15 1 1",
                  out_valid, out_data, in_ready, last_acc);
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_latency();
      logic [6:0]       codes[4] = '{7'h10, 7'h25, 7'h7F, 7'h03};
      logic [INT_W-1:0] exp0[4]  = '{11'd16, 11'd42, 11'd1984, 11'd3};
      logic [INT_W-1:0] exp1[4]  = '{11'd16, 11'd43, 11'd2016, 11'd3};
      int               lats[4]  = '{1, 2, 7, 1};
      int               nbs[4]   = '{1, 2, 7, 1};
      for (int i = 0; i < 4; i++) begin
         int lat, nb;
         wait_idle();
         out_ready = 1'b1; in_valid = 1'b1; in_data = codes[i];
         tick();
         in_valid = 1'b0;
         lat = 1; nb = busy ? 1 : 0;
         while (!out_valid && lat < 20) begin tick(); lat++; if (busy) nb++; end
         n_checks++;
         if (lat != lats[i] || out_data !== exp0[i] || out_data_mp !== exp1[i]) begin
            n_fail++;
            $display("FAIL latency_%02h: lat=%0d data=%0d/%0d expected lat=%0d data=%0d/%0d",
                     codes[i], lat, out_data, out_data_mp, lats[i], exp0[i], exp1[i]);
         end
         while (busy && lat < 40) begin tick(); lat++; if (busy) nb++; end
         n_checks++;
         if (nb != nbs[i]) begin
            n_fail++;
            $display("FAIL busy_%02h: busy cycles=%0d expected %0d", codes[i], nb, nbs[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int n = 0;
      wait_idle();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 7'h3A;
      tick();
      in_data = 7'h45;
      while (!out_valid && n < 20) begin tick(); n++; end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 11'd104 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold%0d: vld=%0b data=%0d rdy=%0b expected 1 104 0",
                     i, out_valid, out_data, in_ready);
         end
         tick();
         n_checks++;
         if (last_acc) begin n_fail++; $display("FAIL bp_taken%0d: accept=1 expected 0", i); end
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: rdy=%0b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (!last_acc) begin n_fail++; $display("FAIL bp_same_cycle: accept=0 expected 1"); end
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      n_checks++;
      if (out_data !== 11'd168 || out_data_mp !== 11'd172) begin
         n_fail++;
         $display("FAIL bp_next: data=%0d/%0d expected 168/172", out_data, out_data_mp);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int n = 0;
      wait_idle();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 7'h60;
      tick();
      in_valid = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== '0 || conv_count !== '0) begin
         n_fail++;
         $display("FAIL async_reset: rdy=%0b vld=%0b busy=%0b data=%0d cnt=%0d expected 1 0 0 0 0",
                  in_ready, out_valid, busy, out_data, conv_count);
      end
      sbq.delete();
      hs = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      in_valid = 1'b1; in_data = 7'h11;
      tick();
      in_valid = 1'b0;
      while (!out_valid && n < 20) begin tick(); n++; end
      n_checks++;
      if (out_data !== 11'd17) begin n_fail++; $display("FAIL post_reset: data=%0d expected 17", out_data); end
      tick();
      n_checks++;
      if (conv_count !== 16'd1) begin
         n_fail++;
         $display("FAIL post_reset_cnt: conv_count=%0d expected 1", conv_count);
      end
   endtask

   task automatic test_random_sweep();
      int idx = 0, cyc = 0;
      while (idx < 128 && cyc < 5000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = in_valid ? 7'((idx * 37) % 128) : 7'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
         if (last_acc) idx++;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      cyc = 0;
      while ((sbq.size() != 0 || busy) && cyc < 100) begin tick(); cyc++; end
      n_checks++;
      if (idx != 128 || sbq.size() != 0) begin
         n_fail++;
         $display("FAIL sweep_done: accepted=%0d pending=%0d expected 128 0", idx, sbq.size());
      end
      n_checks++;
      if (conv_count !== 16'(hs) || conv_count_mp !== 16'(hs)) begin
         n_fail++;
         $display("FAIL sweep_count: conv_count=%0d/%0d expected %0d", conv_count, conv_count_mp, hs);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_latency();
      test_backpressure();
      test_reset_mid();
      test_random_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
